// File: rtl/store_drain_ctrl.sv
// Store buffer pointer bookkeeping plus in-order drain of committed stores,
// sharing the single data-memory port with loads.
module store_drain_ctrl #(
    parameter int DEPTH        = 16,
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int DRAIN_THRESH = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic                     commit_valid,
    input  logic                     flush,
    output logic [$clog2(DEPTH)-1:0] sb_rd_idx,
    input  logic [AW-1:0]            sb_addr,
    input  logic [DW-1:0]            sb_data,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_grant,
    output logic                     ld_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   committed_cnt,
    output logic                     empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] alloc_ptr, commit_ptr, drain_ptr;
    logic [PW-1:0] alloc_ptr_nxt, commit_ptr_nxt, drain_ptr_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          mem_req_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          has_committed;
    logic          store_sel;

    // Status is derived from registered pointers only, so a drain frees its
    // slot one cycle after the ack.
    assign occupancy     = alloc_ptr - drain_ptr;
    assign committed_cnt = commit_ptr - drain_ptr;
    assign empty         = (occupancy == '0);
    assign alloc_ready   = (occupancy < PW'(DEPTH));
    assign alloc_idx     = alloc_ptr[IW-1:0];
    assign sb_rd_idx     = drain_ptr[IW-1:0];
    assign has_committed = (committed_cnt != '0);

    always_comb begin
        commit_ptr_nxt = commit_ptr;
        alloc_ptr_nxt  = alloc_ptr;
        if (commit_valid && (commit_ptr != alloc_ptr)) begin
            commit_ptr_nxt = commit_ptr + PW'(1);
        end
        // Flush rewinds to the commit point after this cycle's commit.
        if (flush) begin
            alloc_ptr_nxt = commit_ptr_nxt;
        end else if (alloc_valid && alloc_ready) begin
            alloc_ptr_nxt = alloc_ptr + PW'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_ptr_nxt = drain_ptr;
        starve_nxt    = starve_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        ld_grant      = 1'b0;
        ld_done       = 1'b0;
        store_sel     = has_committed &&
                        ((committed_cnt >= PW'(DRAIN_THRESH)) ||
                         (starve_cnt >= SW'(STARVE_LIMIT)) || !ld_req);
        case (state)
            IDLE: begin
                if (store_sel) begin
                    mem_addr_nxt  = sb_addr;
                    mem_wdata_nxt = sb_data;
                    mem_we_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    starve_nxt    = '0;
                    state_nxt     = STORE;
                end else if (ld_req) begin
                    ld_grant     = rst_n;
                    mem_addr_nxt = ld_addr;
                    mem_we_nxt   = 1'b0;
                    mem_req_nxt  = 1'b1;
                    if (has_committed && (starve_cnt < SW'(STARVE_LIMIT))) begin
                        starve_nxt = starve_cnt + SW'(1);
                    end
                    state_nxt = LOAD;
                end
            end
            STORE: begin
                if (mem_ack) begin
                    drain_ptr_nxt = drain_ptr + PW'(1);
                    mem_req_nxt   = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            LOAD: begin
                if (mem_ack) begin
                    ld_done     = 1'b1;
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alloc_ptr  <= '0;
            commit_ptr <= '0;
            drain_ptr  <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            alloc_ptr  <= alloc_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            drain_ptr  <= drain_ptr_nxt;
            starve_cnt <= starve_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Scoreboard bench for store_drain_ctrl: directed stimulus pushes expected
// memory transactions; a negedge monitor pops and compares on each ack.
module tb_store_drain_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic        commit_valid;
    logic        flush;
    logic [3:0]  sb_rd_idx;
    logic [15:0] sb_addr;
    logic [7:0]  sb_data;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic        ld_grant;
    logic        ld_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [4:0]  occupancy;
    logic [4:0]  committed_cnt;
    logic        empty;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t        exp_q[$];
    int          ack_cyc_q[$];
    txn_t        mon_t;
    logic [15:0] sb_addr_arr[16];
    logic [7:0]  sb_data_arr[16];
    logic        ack_en;
    int          tests;
    int          fails;
    int          grant_cnt;
    int          cyc;

    store_drain_ctrl #(
        .DEPTH(16), .AW(16), .DW(8), .DRAIN_THRESH(8), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .commit_valid(commit_valid), .flush(flush),
        .sb_rd_idx(sb_rd_idx), .sb_addr(sb_addr), .sb_data(sb_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant), .ld_done(ld_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .occupancy(occupancy), .committed_cnt(committed_cnt), .empty(empty)
    );

    assign sb_addr = sb_addr_arr[sb_rd_idx];
    assign sb_data = sb_data_arr[sb_rd_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acknowledges in the first cycle a request is visible.
    always @(posedge clk) begin
        #2;
        mem_ack = ack_en && mem_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_grant) grant_cnt++;
            if (mem_req && mem_ack) begin
                ack_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(mon_t.we));
                    chk("mem_addr", 32'(mem_addr), 32'(mon_t.addr));
                    if (mon_t.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_t.data));
                    chk("ld_done", 32'(ld_done), 32'(!mon_t.we));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic do_alloc(input int idx, input logic [15:0] a, input logic [7:0] d);
        chk("alloc_idx", 32'(alloc_idx), 32'(idx));
        sb_addr_arr[idx] = a;
        sb_data_arr[idx] = d;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_commit(input int idx, input bit push);
        if (push) push_exp(1'b1, sb_addr_arr[idx], sb_data_arr[idx]);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; ld_req = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        grant_cnt = 0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_drained_neg(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0; grant_cnt = 0;
        rst_n = 1'b0; alloc_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ack_en = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb_addr_arr[i] = '0;
            sb_data_arr[i] = '0;
        end

        // Reset values
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_ld_grant", 32'(ld_grant), 0);
        chk("rst_ld_done", 32'(ld_done), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_idx", 32'(alloc_idx), 0);
        chk("rst_sb_rd_idx", 32'(sb_rd_idx), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_committed", 32'(committed_cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three stores drained in order, two cycles apart
        ack_en = 1'b1;
        ack_cyc_q.delete();
        for (int i = 0; i < 3; i++) do_alloc(i, 16'h1000 + 16'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) do_commit(i, 1'b1);
        wait_drained("t1_drain", 20);
        chk("t1_acks", 32'(ack_cyc_q.size()), 3);
        if (ack_cyc_q.size() == 3) begin
            chk("t1_gap01", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 2);
            chk("t1_gap12", 32'(ack_cyc_q[2] - ack_cyc_q[1]), 2);
        end
        chk("t1_sb_rd_idx", 32'(sb_rd_idx), 3);
        chk("t1_empty", 32'(empty), 1);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        tick();
        chk("t1_idle_commit", 32'(committed_cnt), 0);
        chk("t1_idle_occ", 32'(occupancy), 0);

        // Fill to 16, reject the 17th, free one slot by draining
        for (int k = 0; k < 16; k++) do_alloc((3 + k) % 16, 16'h1100 + 16'(k), 8'h40 + 8'(k));
        chk("t2_full_occ", 32'(occupancy), 16);
        chk("t2_full_ready", 32'(alloc_ready), 0);
        chk("t2_full_empty", 32'(empty), 0);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("t2_17th_occ", 32'(occupancy), 16);
        chk("t2_17th_idx", 32'(alloc_idx), 3);
        do_commit(3, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!mem_ack && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("t2_ack_seen", 32'(mem_ack), 1);
            chk("t2_ack_ready", 32'(alloc_ready), 0);
            chk("t2_ack_occ", 32'(occupancy), 16);
            @(negedge clk);
            chk("t2_after_ready", 32'(alloc_ready), 1);
            chk("t2_after_occ", 32'(occupancy), 15);
        end
        tick();

        // Flush keeps committed entries, drops same-cycle alloc
        do_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) do_alloc(i, 16'h2100 + 16'(i), 8'h20 + 8'(i));
        do_commit(0, 1'b1);
        do_commit(1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_occ", 32'(occupancy), 2);
        chk("t3_flush_idx", 32'(alloc_idx), 2);
        chk("t3_flush_cc", 32'(committed_cnt), 2);
        do_alloc(2, 16'h2200, 8'h30);
        chk("t3_realloc_occ", 32'(occupancy), 3);
        do_alloc(3, 16'h2300, 8'h31);
        do_alloc(4, 16'h2400, 8'h32);
        push_exp(1'b1, 16'h2200, 8'h30);
        commit_valid = 1'b1; flush = 1'b1; alloc_valid = 1'b1;
        tick();
        commit_valid = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
        chk("t3_cf_occ", 32'(occupancy), 3);
        chk("t3_cf_idx", 32'(alloc_idx), 3);
        chk("t3_cf_cc", 32'(committed_cnt), 3);
        ack_en = 1'b1;
        wait_drained("t3_drain", 20);
        chk("t3_empty", 32'(empty), 1);
        chk("t3_sb_rd_idx", 32'(sb_rd_idx), 3);

        // Starvation: four loads with stores pending, then a forced store
        do_reset();
        ack_en = 1'b0;
        ld_addr = 16'h4000;
        ld_req = 1'b1;
        push_exp(1'b0, 16'h4000, 8'h00);
        tick();
        tick();
        do_alloc(0, 16'h4100, 8'h41);
        do_alloc(1, 16'h4101, 8'h42);
        do_commit(0, 1'b0);
        do_commit(1, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h4000, 8'h00);
        push_exp(1'b1, 16'h4100, 8'h41);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h4000, 8'h00);
        push_exp(1'b1, 16'h4101, 8'h42);
        ack_en = 1'b1;
        wait_drained_neg("t4_drain", 60);
        ld_req = 1'b0;
        tick();
        tick();
        chk("t4_grants", 32'(grant_cnt), 9);
        chk("t4_empty", 32'(empty), 1);

        // Threshold: eight committed stores beat a pending load
        do_reset();
        ack_en = 1'b0;
        ld_addr = 16'h5000;
        ld_req = 1'b1;
        push_exp(1'b0, 16'h5000, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 8; i++) do_alloc(i, 16'h5100 + 16'(i), 8'h50 + 8'(i));
        for (int i = 0; i < 8; i++) do_commit(i, 1'b0);
        chk("t5_cc", 32'(committed_cnt), 8);
        push_exp(1'b1, 16'h5100, 8'h50);
        ack_en = 1'b1;
        wait_drained_neg("t5_first", 30);
        ld_req = 1'b0;
        for (int i = 1; i < 8; i++) push_exp(1'b1, 16'h5100 + 16'(i), 8'h50 + 8'(i));
        tick();
        wait_drained("t5_rest", 40);
        chk("t5_grants", 32'(grant_cnt), 1);
        chk("t5_empty", 32'(empty), 1);

        // Twenty stores through the index wrap
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            do_alloc(i % 16, 16'h6000 + 16'(i), 8'hC0 + 8'(i));
            do_commit(i % 16, 1'b1);
        end
        wait_drained("t6_drain", 40);
        chk("t6_occ", 32'(occupancy), 0);
        chk("t6_sb_rd_idx", 32'(sb_rd_idx), 4);
        chk("t6_alloc_idx", 32'(alloc_idx), 4);
        chk("t6_empty", 32'(empty), 1);

        // Asynchronous reset while a store is outstanding
        ack_en = 1'b0;
        do_alloc(4, 16'h7000, 8'h77);
        do_commit(4, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!mem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("t7_req_up", 32'(mem_req), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_req", 32'(mem_req), 0);
        chk("t7_rst_occ", 32'(occupancy), 0);
        chk("t7_rst_we", 32'(mem_we), 0);
        chk("t7_rst_idx", 32'(alloc_idx), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (4) tick();
        chk("t7_post_req", 32'(mem_req), 0);
        chk("t7_post_empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_drain_ctrl.md
# store_drain_ctrl

Controller for the 16-entry store buffer and the single data-memory port. It tracks allocated, committed and drained store entries with three circular pointers and hands out buffer slots to dispatch. It retires committed stores to memory in program order and arbitrates that one memory port between store drains and load requests. It sits between dispatch/ROB commit, the store buffer storage, and data memory.

## Interface
- DEPTH, 16, store buffer entries (power of two)
- AW, 16, address width
- DW, 8, data width
- DRAIN_THRESH, 8, committed-entry count at or above which stores beat loads
- STARVE_LIMIT, 4, consecutive load grants with stores pending before a store is forced
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests a store slot
- alloc_ready  out  1  slot available (occupancy < DEPTH)
- alloc_idx  out  4  slot index for this allocation (alloc_ptr[3:0])
- commit_valid  in  1  ROB commits oldest uncommitted store
- flush  in  1  discard all uncommitted entries
- sb_rd_idx  out  4  buffer entry to read (drain_ptr[3:0])
- sb_addr  in  AW  buffer address at sb_rd_idx
- sb_data  in  DW  buffer data at sb_rd_idx
- ld_req  in  1  load wants the memory port
- ld_addr  in  AW  load address
- ld_grant  out  1  one-cycle pulse: load accepted
- ld_done  out  1  load memory access complete (mem_ack while serving a load)
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  AW  request address
- mem_wdata  out  DW  store data
- mem_ack  in  1  memory completes current request
- occupancy  out  5  alloc_ptr - drain_ptr
- committed_cnt  out  5  commit_ptr - drain_ptr
- empty  out  1  occupancy == 0

## Operation
- Pointers alloc_ptr, commit_ptr, drain_ptr are 5 bits (wrap bit + index); all arithmetic modulo 32.
- Allocate: alloc_valid && alloc_ready && !flush -> alloc_ptr += 1.
- Commit: commit_valid && commit_ptr != alloc_ptr -> commit_ptr += 1; commit with no uncommitted entry is ignored.
- Flush: alloc_ptr <= commit_ptr after that cycle's commit is applied; same-cycle alloc dropped; committed and in-flight entries unaffected.
- FSM states IDLE, LOAD, STORE.
- IDLE: store selected if committed_cnt > 0 and (committed_cnt >= DRAIN_THRESH or starve_cnt >= STARVE_LIMIT or !ld_req); else load selected if ld_req; else stay.
- Store select: latch mem_addr <= sb_addr, mem_wdata <= sb_data, mem_we <= 1, mem_req <= 1, starve_cnt <= 0, -> STORE.
- Load select: ld_grant = 1 that cycle, latch mem_addr <= ld_addr, mem_we <= 0, mem_req <= 1, starve_cnt += 1 (saturating at STARVE_LIMIT) if committed_cnt > 0, -> LOAD.
- STORE: on mem_ack, drain_ptr += 1, mem_req <= 0, -> IDLE.
- LOAD: on mem_ack, ld_done = 1, mem_req <= 0, -> IDLE.
- mem_addr/mem_wdata/mem_we stable while mem_req high.

## Timing
- Reset: all pointers 0, starve_cnt 0, state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ld_grant 0, ld_done 0, alloc_ready 1, alloc_idx 0, sb_rd_idx 0, occupancy 0, committed_cnt 0, empty 1.
- alloc_ready, occupancy, committed_cnt, empty, alloc_idx, sb_rd_idx derive from registered pointers only; a same-cycle drain does not free a slot until next cycle.
- ld_grant, ld_done combinational from state and inputs; mem_* registered.
- Arbitration decision in IDLE cycle N; mem_req high from N+1 through ack cycle inclusive; low at ack+1 (IDLE). Minimum 2 cycles per transaction, back-to-back transactions spaced by one IDLE cycle.
- Commit of entry in cycle N makes it drainable at cycle N+1 arbitration.
- Full (occupancy 16): alloc_ready 0; in-flight store entry still counts until ack.
- Wrap: index 15 -> 0 with wrap-bit toggle; full vs. empty distinguished by wrap bit.
- rst_n low mid-transaction: immediate return to reset values; no ack is tracked.

## Test plan
- Reset, alloc 3, commit 3, ld_req 0 -> three STORE transactions with mem_ack after 1 cycle; drain_ptr 3, empty 1, mem_we 1 each, one IDLE cycle between.
- Alloc 16 with no commit -> alloc_ready 0 at occupancy 16, 17th alloc ignored; commit 1 + ack -> alloc_ready 1 the cycle after ack.
- Alloc 5, commit 2, flush -> occupancy 2, alloc_idx 2; next alloc gets index 2; commit same cycle as flush gives occupancy 3.
- Committed 2, ld_req held high -> 4 load grants, then forced store (starve_cnt = 4), starve_cnt cleared.
- Committed reaches 8 with ld_req high -> store wins immediately.
- Drain 20 stores through wrap -> indices 0..15,0..3 in order; rst_n low while mem_req high -> mem_req 0, occupancy 0 at once.
